rca_accumulator: RTL and testbench

RCA_ACCUMULATOR -- requirements
Module: rca_accumulator

---
 rtl/rca_accumulator_if.sv | 40 ++++
 rtl/rca_accumulator.sv | 110 +++++++++++
 tb/tb_rca_accumulator.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rca_accumulator_if.sv
// Handshake bundle between an RCA adder stage, the frame accumulator and the
// frame-total consumer. The slave modport is the accumulator's view.
interface rca_accumulator_if #(
    parameter int N = 4
) ();
    localparam int ACC_W = N + 5;

    logic             clear;
    logic             in_valid;
    logic [N-1:0]     Sum;
    logic             carry_out;
    logic             in_ready;
    logic             out_ready;
    logic             out_valid;
    logic [ACC_W-1:0] acc_out;

    // Producer/consumer side: drives samples and the output handshake.
    modport master (
        output clear,
        output in_valid,
        output Sum,
        output carry_out,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  acc_out
    );

    // Accumulator side.
    modport slave (
        input  clear,
        input  in_valid,
        input  Sum,
        input  carry_out,
        input  out_ready,
        output in_ready,
        output out_valid,
        output acc_out
    );
endinterface

// File: rtl/rca_accumulator.sv
// Frame accumulator for adder results: sums CNT samples of {carry_out,Sum},
// then holds the total until the consumer takes it. Outputs depend on
// registered state only, so no input-to-output combinational path exists.
module rca_accumulator #(
    parameter int N   = 4,
    parameter int CNT = 4
) (
    input logic              clk,
    input logic              rst,
    rca_accumulator_if.slave bus
);
    localparam int ACC_W = N + 5;
    // 5 bits covers every counter value for CNT up to 16.
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] sum_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [ACC_W-1:0] sample;
    logic [ACC_W-1:0] total;
    logic             accept;
    logic             last;

    // Sample widening, acceptance and running-total arithmetic.
    always_comb begin
        sample = ACC_W'({bus.carry_out, bus.Sum});
        total  = sum_q + sample;
        accept = bus.in_valid && (state_q == ACCUM);
        last   = (cnt_q == LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear overrides any handshake in either state.
    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (accept && last) state_d = HOLD;
                HOLD:    if (bus.out_ready)  state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Datapath next values: clear drops the partial frame but keeps acc_out.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (bus.clear) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (last) begin
                acc_d = total;
                sum_d = '0;
                cnt_d = '0;
            end else begin
                sum_d = total;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    // Output decode from state and registers only.
    always_comb begin
        bus.in_ready  = (state_q == ACCUM);
        bus.out_valid = (state_q == HOLD);
        bus.acc_out   = acc_q;
    end

    // The counter never reaches CNT; the final sample wraps it to zero.
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt_q < CNT_W'(CNT));

endmodule

// File: tb/tb_rca_accumulator.sv
// Bench for rca_accumulator (N=4, CNT=4): directed scenarios with literal
// expectations plus a randomized adder chain, all checked each cycle against
// a frame-level model (list of accepted samples, pending-result flag).
module tb_rca_accumulator;
    localparam int N     = 4;
    localparam int CNT   = 4;
    localparam int ACC_W = N + 5;

    logic clk;
    logic rst;

    rca_accumulator_if #(.N(N)) bus ();

    rca_accumulator #(.N(N), .CNT(CNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state.
    int   frame_q[$];
    int   exp_acc  = 0;
    bit   pending  = 1'b0;
    bit   model_on = 1'b0;
    int   frames   = 0;

    always @(posedge clk) begin
        if (rst) begin
            frame_q.delete();
            pending  = 1'b0;
            exp_acc  = 0;
            model_on = 1'b1;
        end else if (bus.clear) begin
            frame_q.delete();
            pending = 1'b0;
        end else if (pending) begin
            if (bus.out_ready) pending = 1'b0;
        end else if (bus.in_valid) begin
            frame_q.push_back(int'({bus.carry_out, bus.Sum}));
            if (frame_q.size() == CNT) begin
                exp_acc = 0;
                foreach (frame_q[k]) exp_acc += frame_q[k];
                frame_q.delete();
                pending = 1'b1;
                frames++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on) begin
            tests++;
            if (bus.in_ready !== !pending) begin
                fails++;
                $display("FAIL cyc_in_ready t=%0t act=%b exp=%b", $time, bus.in_ready, !pending);
            end
            tests++;
            if (bus.out_valid !== pending) begin
                fails++;
                $display("FAIL cyc_out_valid t=%0t act=%b exp=%b", $time, bus.out_valid, pending);
            end
            tests++;
            if (bus.acc_out !== ACC_W'(exp_acc)) begin
                fails++;
                $display("FAIL cyc_acc_out t=%0t act=%0d exp=%0d", $time, bus.acc_out, exp_acc);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int acc, input int ov, input int ir);
        check({name, "_acc"}, int'(bus.acc_out), acc);
        check({name, "_ov"},  int'(bus.out_valid), ov);
        check({name, "_ir"},  int'(bus.in_ready), ir);
    endtask

    task automatic send(input logic [4:0] v);
        bus.Sum       = v[3:0];
        bus.carry_out = v[4];
        bus.in_valid  = 1'b1;
        cycle();
        bus.in_valid  = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
    endtask

    logic [3:0] a, b;
    logic       cin;
    logic [4:0] s;

    initial begin
        rst           = 1'b1;
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.Sum       = '0;
        bus.carry_out = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held two cycles.
        cycle();
        cycle();
        check_out("reset", 0, 0, 1);
        rst = 1'b0;

        // Max operands back-to-back, result held while out_ready low;
        // in_valid kept high in HOLD must be ignored.
        bus.Sum = 4'hF; bus.carry_out = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < CNT; i++) cycle();
        check_out("max_done", 124, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_out("max_hold", 124, 1, 0);
        end
        bus.in_valid = 1'b0;
        handshake();
        check_out("max_release", 124, 0, 1);

        // Gapped samples with out_ready high during accumulation.
        bus.out_ready = 1'b1;
        send(5'd3);  cycle(); cycle();
        send(5'd0);  cycle(); cycle();
        send(5'd17); cycle(); cycle();
        check_out("gap_pre", 124, 0, 1);
        bus.out_ready = 1'b0;
        send(5'd5);
        check_out("gap_done", 25, 1, 0);
        handshake();
        check_out("gap_release", 25, 0, 1);

        // Clear mid-frame with a sample presented.
        send(5'd10);
        send(5'd10);
        bus.clear = 1'b1;
        send(5'd7);
        bus.clear = 1'b0;
        for (int i = 0; i < CNT; i++) send(5'd1);
        check_out("clear_done", 4, 1, 0);
        handshake();

        // Clear during HOLD drops the pending result, acc_out stays.
        for (int i = 0; i < CNT; i++) send(5'd6);
        check_out("clrhold_done", 24, 1, 0);
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        check_out("clrhold_after", 24, 0, 1);

        // Reset in HOLD, then a fresh frame.
        for (int i = 0; i < CNT; i++) send(5'd10);
        check_out("rsthold_done", 40, 1, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_out("rsthold_after", 0, 0, 1);
        for (int i = 0; i < CNT; i++) send(5'd2);
        check_out("rsthold_next", 8, 1, 0);
        handshake();

        // Randomized adder chain: A + B + carry_in feeding the accumulator.
        for (int i = 0; i < 200; i++) begin
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            s   = 5'(a) + 5'(b) + 5'(cin);
            bus.Sum       = s[3:0];
            bus.carry_out = s[4];
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) == 0);
            bus.clear     = ($urandom_range(0, 63) == 0);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.clear     = 1'b0;
        cycle();
        tests++;
        if (frames < 10) begin
            fails++;
            $display("FAIL rand_frames act=%0d exp=>=10", frames);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
